// File: rtl/branch_target_predictor_if.sv
// Fetch/update bundle shared by the branch target predictor and its client.
// The master modport belongs to the fetch/EX side. The slave modport belongs
// to the predictor.
interface branch_target_predictor_if;
  logic [63:0] fetch_pc;
  logic        prediction;
  logic [63:0] predicted_pc;
  logic        btb_hit;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic [63:0] upd_target;
  logic        upd_taken;
  logic        upd_is_jump;

  modport master (
    output fetch_pc,
    output upd_valid,
    output upd_pc,
    output upd_target,
    output upd_taken,
    output upd_is_jump,
    input  prediction,
    input  predicted_pc,
    input  btb_hit
  );

  modport slave (
    input  fetch_pc,
    input  upd_valid,
    input  upd_pc,
    input  upd_target,
    input  upd_taken,
    input  upd_is_jump,
    output prediction,
    output predicted_pc,
    output btb_hit
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Fetch-stage branch predictor built from two parts:
// - a direct-mapped BTB indexed by pc[IDX_W+1:2], with tag pc[IDX_W+TAG_W+1:IDX_W+2];
// - a 2-bit saturating counter per entry.
// Lookup is combinational. Training from EX commits on the rising clock edge.
// Optional feature macro: BTP_BYPASS_EN. It forwards a same-cycle update to a
// lookup that has the same index and tag as the update.
module branch_target_predictor #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 16
) (
  input logic                       clk,
  input logic                       arst_n,
  branch_target_predictor_if.slave  bus
);

  localparam int DEPTH  = 1 << IDX_W;
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_W + 1;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
  endfunction

  function automatic logic [IDX_W-1:0] pc_idx(input logic [63:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [63:0] pc);
    return pc[TAG_HI:TAG_LO];
  endfunction

  // Entry storage. Only valid and ctr carry reset; tag and target are data.
  logic [DEPTH-1:0] valid_q;
  ctr_t             ctr_q    [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [63:0]      target_q [DEPTH];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;

  assign fetch_idx = pc_idx(bus.fetch_pc);
  assign fetch_tag = pc_tag(bus.fetch_pc);
  assign upd_idx   = pc_idx(bus.upd_pc);
  assign upd_tag   = pc_tag(bus.upd_pc);

  // Byte-offset bits and bits above the tag do not take part in lookup.
  // Aliasing across those high bits is accepted.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.fetch_pc[1:0], bus.fetch_pc[63:TAG_HI+1],
                            bus.upd_pc[1:0], bus.upd_pc[63:TAG_HI+1]};

  // Post-update value of the entry selected by upd_pc, plus its write enable.
  logic             upd_hit;
  logic             upd_we;
  logic             nxt_valid;
  logic [TAG_W-1:0] nxt_tag;
  logic [63:0]      nxt_target;
  ctr_t             nxt_ctr;

  // Build the next value of the trained entry from the resolved outcome.
  always_comb begin
    upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_we     = 1'b0;
    nxt_valid  = valid_q[upd_idx];
    nxt_tag    = tag_q[upd_idx];
    nxt_target = target_q[upd_idx];
    nxt_ctr    = ctr_q[upd_idx];
    if (bus.upd_valid) begin
      if (upd_hit) begin
        upd_we = 1'b1;
        if (bus.upd_is_jump) begin
          nxt_ctr    = CTR_ST;
          nxt_target = bus.upd_target;
        end else if (bus.upd_taken) begin
          nxt_ctr    = ctr_inc(ctr_q[upd_idx]);
          nxt_target = bus.upd_target;
        end else begin
          nxt_ctr    = ctr_dec(ctr_q[upd_idx]);
        end
      end else if (bus.upd_taken) begin
        // A taken miss evicts whatever currently occupies this index.
        upd_we     = 1'b1;
        nxt_valid  = 1'b1;
        nxt_tag    = upd_tag;
        nxt_target = bus.upd_target;
        nxt_ctr    = bus.upd_is_jump ? CTR_ST : CTR_WT;
      end
    end
  end

  // Control state. Reset clears every entry and drops a same-edge update.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= CTR_WNT;
      end
    end else if (upd_we) begin
      valid_q[upd_idx] <= nxt_valid;
      ctr_q[upd_idx]   <= nxt_ctr;
    end
  end

  // Tag and target payload. No reset; it is meaningless while valid is low.
  always_ff @(posedge clk) begin
    if (arst_n && upd_we) begin
      tag_q[upd_idx]    <= nxt_tag;
      target_q[upd_idx] <= nxt_target;
    end
  end

  logic             look_valid;
  logic [TAG_W-1:0] look_tag;
  logic [63:0]      look_target;
  ctr_t             look_ctr;
  logic             look_hit;
  logic             look_pred;

  // Combinational lookup of fetch_pc. The bypass build can optionally
  // forward a same-cycle update.
  always_comb begin
    look_valid  = valid_q[fetch_idx];
    look_tag    = tag_q[fetch_idx];
    look_target = target_q[fetch_idx];
    look_ctr    = ctr_q[fetch_idx];
`ifdef BTP_BYPASS_EN
    if (bus.upd_valid && (upd_idx == fetch_idx) && (upd_tag == fetch_tag)) begin
      look_valid  = nxt_valid;
      look_tag    = nxt_tag;
      look_target = nxt_target;
      look_ctr    = nxt_ctr;
    end
`endif
    look_hit  = look_valid && (look_tag == fetch_tag);
    look_pred = look_hit && look_ctr[1];
  end

  assign bus.btb_hit      = look_hit;
  assign bus.prediction   = look_pred;
  assign bus.predicted_pc = look_pred ? look_target : 64'd0;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor.
// Inputs change just after a rising edge, and outputs are checked before the
// next edge.
module tb_branch_target_predictor;

  logic clk;
  logic arst_n;
  int   tests;
  int   fails;

  branch_target_predictor_if bus ();

  branch_target_predictor #(
    .IDX_W (4),
    .TAG_W (16)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [63:0] pc);
    bus.fetch_pc = pc;
    #1;
  endtask

  task automatic upd(input logic [63:0] pc, input logic [63:0] tgt,
                     input logic taken, input logic jump);
    bus.upd_valid   = 1'b1;
    bus.upd_pc      = pc;
    bus.upd_target  = tgt;
    bus.upd_taken   = taken;
    bus.upd_is_jump = jump;
  endtask

  task automatic upd_off();
    bus.upd_valid   = 1'b0;
    bus.upd_pc      = 64'd0;
    bus.upd_target  = 64'd0;
    bus.upd_taken   = 1'b0;
    bus.upd_is_jump = 1'b0;
  endtask

  // Trains one update in the cycle, then releases it after the edge.
  task automatic train(input logic [63:0] pc, input logic [63:0] tgt,
                       input logic taken, input logic jump);
    bus.fetch_pc = 64'h0000_0000_00F0_0004;
    upd(pc, tgt, taken, jump);
    tick();
    upd_off();
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    arst_n = 1'b0;
    bus.fetch_pc = 64'd0;
    upd_off();
    tick();
    tick();
    arst_n = 1'b1;

    // Check the reset state.
    look(64'h100);
    check("rst_hit",  64'(bus.btb_hit),    64'd0);
    check("rst_pred", 64'(bus.prediction), 64'd0);
    check("rst_ppc",  bus.predicted_pc,    64'd0);

    // Allocate on a taken miss; the counter starts at weak taken.
    train(64'h100, 64'h200, 1'b1, 1'b0);
    look(64'h100);
    check("alloc_hit",  64'(bus.btb_hit),    64'd1);
    check("alloc_pred", 64'(bus.prediction), 64'd1);
    check("alloc_ppc",  bus.predicted_pc,    64'h200);

    // Not-taken training moves the counter 10 -> 01 -> 00.
    train(64'h100, 64'h0, 1'b0, 1'b0);
    look(64'h100);
    check("nt1_hit",  64'(bus.btb_hit),    64'd1);
    check("nt1_pred", 64'(bus.prediction), 64'd0);
    check("nt1_ppc",  bus.predicted_pc,    64'd0);
    train(64'h100, 64'h0, 1'b0, 1'b0);
    look(64'h100);
    check("nt2_hit",  64'(bus.btb_hit),    64'd1);
    check("nt2_pred", 64'(bus.prediction), 64'd0);

    // Floor check: one more not-taken leaves 00, so two taken updates are
    // needed to predict again.
    train(64'h100, 64'h0, 1'b0, 1'b0);
    train(64'h100, 64'h200, 1'b1, 1'b0);
    look(64'h100);
    check("floor_pred", 64'(bus.prediction), 64'd0);

    // Taken training saturates the counter at 11, and the target is updated.
    train(64'h100, 64'h200, 1'b1, 1'b0);
    train(64'h100, 64'h200, 1'b1, 1'b0);
    train(64'h100, 64'h200, 1'b1, 1'b0);
    train(64'h100, 64'h208, 1'b1, 1'b0);
    look(64'h100);
    check("sat_pred", 64'(bus.prediction), 64'd1);
    check("sat_ppc",  bus.predicted_pc,    64'h208);

    // From 11, one not-taken gives 10 and the target stays unchanged.
    train(64'h100, 64'hDEAD, 1'b0, 1'b0);
    look(64'h100);
    check("sat_nt_pred", 64'(bus.prediction), 64'd1);
    check("sat_nt_ppc",  bus.predicted_pc,    64'h208);
    train(64'h100, 64'h0, 1'b0, 1'b0);
    look(64'h100);
    check("sat_nt2_pred", 64'(bus.prediction), 64'd0);

    // A jump allocation gives 11 and shares index 0 with 0x100.
    train(64'h140, 64'h80, 1'b1, 1'b1);
    look(64'h140);
    check("jmp_pred", 64'(bus.prediction), 64'd1);
    check("jmp_ppc",  bus.predicted_pc,    64'h80);
    look(64'h100);
    check("jmp_evict_hit", 64'(bus.btb_hit), 64'd0);
    train(64'h140, 64'h0, 1'b0, 1'b0);
    look(64'h140);
    check("jmp_nt1_pred", 64'(bus.prediction), 64'd1);
    train(64'h140, 64'h0, 1'b0, 1'b0);
    look(64'h140);
    check("jmp_nt2_pred", 64'(bus.prediction), 64'd0);

    // Alias test: 0x1100 replaces 0x100 at the same index with a different tag.
    train(64'h100, 64'h200, 1'b1, 1'b0);
    train(64'h1100, 64'h300, 1'b1, 1'b0);
    look(64'h100);
    check("alias_old_hit", 64'(bus.btb_hit), 64'd0);
    look(64'h1100);
    check("alias_new_hit", 64'(bus.btb_hit),  64'd1);
    check("alias_new_ppc", bus.predicted_pc,  64'h300);
    look(64'h0000_0001_0040_1103);
    check("alias_high_ppc", bus.predicted_pc, 64'h300);

    // A not-taken miss leaves the current occupant in place.
    train(64'h500, 64'h900, 1'b0, 1'b0);
    look(64'h1100);
    check("nt_miss_hit", 64'(bus.btb_hit), 64'd1);
    look(64'h500);
    check("nt_miss_new", 64'(bus.btb_hit), 64'd0);

    // Same-cycle update and lookup of 0x180.
    upd(64'h180, 64'h400, 1'b1, 1'b0);
    look(64'h180);
`ifdef BTP_BYPASS_EN
    check("same_cyc_pred", 64'(bus.prediction), 64'd1);
    check("same_cyc_ppc",  bus.predicted_pc,    64'h400);
`else
    check("same_cyc_pred", 64'(bus.prediction), 64'd0);
    check("same_cyc_ppc",  bus.predicted_pc,    64'd0);
`endif
    tick();
    upd_off();
    look(64'h180);
    check("next_cyc_pred", 64'(bus.prediction), 64'd1);
    check("next_cyc_ppc",  bus.predicted_pc,    64'h400);

    // Lookup and update at different indices are independent.
    upd(64'h1C4, 64'h700, 1'b1, 1'b0);
    look(64'h180);
    check("indep_ppc", bus.predicted_pc, 64'h400);
    tick();
    upd_off();
    look(64'h1C4);
    check("indep_new_ppc", bus.predicted_pc, 64'h700);

    // Reset wins over a same-edge update and clears the learned entries.
    arst_n = 1'b0;
    upd(64'h1C0, 64'h500, 1'b1, 1'b0);
    tick();
    upd_off();
    arst_n = 1'b1;
    look(64'h1C0);
    check("rst_upd_hit", 64'(bus.btb_hit), 64'd0);
    check("rst_upd_ppc", bus.predicted_pc, 64'd0);
    look(64'h100);
    check("rst_100_hit", 64'(bus.btb_hit), 64'd0);
    look(64'h180);
    check("rst_180_hit", 64'(bus.btb_hit), 64'd0);
    look(64'h1C4);
    check("rst_1c4_hit", 64'(bus.btb_hit), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Fetch-stage branch predictor combining a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters. It sits upstream of the decode-stage control unit. Each cycle it looks up the fetch PC and produces `prediction` and `predicted_pc` for the IF/ID register, which feeds the control unit's flush decision. Resolved branch/jump outcomes from EX train it.

## Interface
- `IDX_W`, 4: index width; BTB depth = 2^IDX_W entries.
- `TAG_W`, 16: stored tag width, taken from PC bits above the index.
- `clk` in 1: clock; all state updates on rising edge.
- `arst_n` in 1: reset, synchronous and active-low.
- `fetch_pc` in 64: PC of the instruction being fetched.
- `prediction` out 1: predict taken for `fetch_pc`.
- `predicted_pc` out 64: predicted target when `prediction`=1, else 64'd0.
- `btb_hit` out 1: valid entry with matching tag for `fetch_pc`.
- `upd_valid` in 1: resolved control-flow instruction in EX this cycle.
- `upd_pc` in 64: PC of the resolved instruction.
- `upd_target` in 64: resolved target address.
- `upd_taken` in 1: branch resolved taken (1 for jumps).
- `upd_is_jump` in 1: instruction is an unconditional jump.

## Operation
- Entry fields: `valid`, `tag[TAG_W]`, `target[64]`, `ctr[2]`.
- Index = `pc[IDX_W+1:2]`. Tag = `pc[IDX_W+TAG_W+1:IDX_W+2]`. Bits [1:0] are ignored. Aliasing above the tag bits is permitted.
- Lookup (combinational):
  - `btb_hit` = valid & tag match.
  - `prediction` = `btb_hit` & `ctr[1]`.
  - `predicted_pc` = `prediction` ? `target` : 0.
- Update, when `upd_valid`=1 at the clock edge. Entry is selected by `upd_pc` index.
  - Tag hit, `upd_is_jump`: `ctr`←11, `target`←`upd_target`.
  - Tag hit, taken: `ctr` saturating increment (max 11), `target`←`upd_target`.
  - Tag hit, not taken: `ctr` saturating decrement (min 00). Target is unchanged.
  - Miss (invalid or tag mismatch), taken: allocate. Set `valid`←1, write tag and target, and set `ctr`←(`upd_is_jump` ? 11 : 10). This replaces any prior occupant.
  - Miss, not taken: no state change.
- Counter meaning: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- `upd_valid`=0: no state change. Other `upd_*` inputs are don't-care.

## Timing
- Lookup latency 0: outputs depend combinationally on `fetch_pc` and current state.
- An update becomes visible to lookups from the cycle after the edge that writes it (unless the bypass macro below is defined).
- Reset (`arst_n`=0 at an edge): all `valid`←0, all `ctr`←01; tags and targets are don't-care.
- Outputs after reset: `btb_hit`=0, `prediction`=0, `predicted_pc`=0 for every `fetch_pc`.
- Reset wins over a same-edge update; that update is dropped.
- Reset asserted mid-operation clears all learned state at that edge. No other pipeline interaction.
- Lookup and update in the same cycle to different indices are independent.

## Configuration
- `BTP_BYPASS_EN` defined:
  - Applies when `upd_valid`=1 and `upd_pc` has the same index and tag as `fetch_pc`.
  - Lookup outputs reflect the post-update entry value in the same cycle (write-through forwarding).
  - State written at the edge is identical to the non-bypass build.
- Not defined: lookup always sees pre-update state. Same-cycle updates are seen only from the next cycle.

## Test plan
- Reset, then `fetch_pc`=0x100: expect `btb_hit`=0, `prediction`=0, `predicted_pc`=0.
- Update `upd_pc`=0x100, `upd_target`=0x200, taken, not jump. Next cycle, lookup 0x100: expect `btb_hit`=1, `prediction`=1 (ctr=10), `predicted_pc`=0x200.
- Train 0x100 not-taken twice more. Expect ctr 10→01→00, `prediction`=0, `predicted_pc`=0, `btb_hit`=1. Five taken updates then saturate ctr at 11, and one not-taken gives 10, still predicted.
- Jump update `upd_pc`=0x140, `upd_target`=0x80, `upd_is_jump`=1 on a miss: next cycle `prediction`=1, `predicted_pc`=0x80.
- Alias test with IDX_W=4:
  - Allocate 0x100 (target 0x200).
  - Taken update at 0x1100 (same index, different tag, target 0x300).
  - Lookup 0x100: `btb_hit`=0. Lookup 0x1100: `predicted_pc`=0x300.
- Same-cycle update and lookup of 0x180 (new entry, target 0x400):
  - Without `BTP_BYPASS_EN`: `prediction`=0 that cycle, 1 the next.
  - With `BTP_BYPASS_EN`: `prediction`=1 and `predicted_pc`=0x400 that cycle.
- Assert `arst_n`=0 together with an update at 0x1C0. Afterwards, lookup 0x1C0 and 0x100: both `btb_hit`=0.
